// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a CHAIN_LEN-bit pattern into a negedge mux-scan chain while unloading it, with an optional capture cycle.
// Latency: done pulses CHAIN_LEN cycles after the accepting edge, or CHAIN_LEN+1 cycles when a capture cycle is added.
// Backpressure: none. start is honoured only in IDLE, abort cancels SHIFT/CAPTURE, and the busy output tells the requester to wait.
//
// Ports:
//   CLK, RSTB            - clock (posedge logic), asynchronous active-low reset
//   start, capture_en    - command request and capture option, both latched in IDLE
//   abort                - cancel the pass in progress (SHIFT or CAPTURE)
//   pattern_in           - pattern to load; bit j ends up in chain flop j
//   scan_so              - serial out of the last chain flop
//   scan_se, scan_si     - chain scan enable / serial in (registered, stable at the chain's negedge)
//   busy, done           - pass in progress / one-cycle completion pulse
//   result_out           - chain contents unloaded by the last completed pass
//   pass_cnt             - completed (non-aborted) pass count, wraps
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
    parameter int PASS_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic                 capture_en,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic                 scan_so,
    output logic                 scan_se,
    output logic                 scan_si,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result_out,
    output logic [PASS_W-1:0]    pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Bits of the pattern still to be sent, MSB next.
    logic [CHAIN_LEN-1:0]   shift_q, shift_d;
    logic                   cap_q, cap_d;
    // Unload assembly register; samples enter at bit 0 and move up, so the
    // first sample (old flop CHAIN_LEN-1) ends up at the MSB.
    logic [CHAIN_LEN-1:0]   asm_q, asm_d;
    logic [CHAIN_LEN-1:0]   result_q, result_d;
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic                   se_q, se_d;
    logic                   si_q, si_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   enter_done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        cap_d      = cap_q;
        asm_d      = asm_q;
        result_d   = result_q;
        pass_d     = pass_q;
        se_d       = 1'b0;
        si_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        enter_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort has no effect here, so start alone decides.
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    cap_d   = capture_en;
                    shift_d = {pattern_in[CHAIN_LEN-2:0], 1'b0};
                    asm_d   = {{(CHAIN_LEN-1){1'b0}}, scan_so};
                    se_d    = 1'b1;
                    si_d    = pattern_in[CHAIN_LEN-1];
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    // All CHAIN_LEN samples are already in asm_q.
                    if (cap_q) begin
                        state_d = S_CAPTURE;
                        busy_d  = 1'b1;
                    end else begin
                        enter_done = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shift_d = {shift_q[CHAIN_LEN-2:0], 1'b0};
                    asm_d   = {asm_q[CHAIN_LEN-2:0], scan_so};
                    se_d    = 1'b1;
                    si_d    = shift_q[CHAIN_LEN-1];
                    busy_d  = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    enter_done = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_done) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b1;
            result_d = asm_q;
            pass_d   = pass_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            cap_q    <= 1'b0;
            asm_q    <= '0;
            result_q <= '0;
            pass_q   <= '0;
            se_q     <= 1'b0;
            si_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            cap_q    <= cap_d;
            asm_q    <= asm_d;
            result_q <= result_d;
            pass_q   <= pass_d;
            se_q     <= se_d;
            si_q     <= si_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign scan_se    = se_q;
    assign scan_si    = si_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result_out = result_q;
    assign pass_cnt   = pass_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl with a negedge mux-scan chain model.
// Latency: checks the exact cycle of every scan output and of the done pulse.
// Backpressure: exercises ignored start, abort and mid-pass reset.
module tb_scan_chain_ctrl;

    localparam int N = 16;

    logic          CLK;
    logic          RSTB;
    logic          start, capture_en, abort;
    logic [N-1:0]  pattern_in;
    logic          scan_so, scan_se, scan_si, busy, done;
    logic [N-1:0]  result_out;
    logic [15:0]   pass_cnt;

    // Small second instance to observe pass counter wrap.
    logic          start2;
    logic [3:0]    pattern2;
    logic          se2, si2, busy2, done2;
    logic [3:0]    result2;
    logic [1:0]    pass2;

    // Chain model: negedge flops, flop 0 fed by scan_si, scan_so from flop N-1.
    logic [N-1:0]  chain;
    logic          func_en;
    logic [N-1:0]  func_val;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0]  exp_chain;
    logic [15:0]   exp_pass;
    logic [N-1:0]  last_res;

    scan_chain_ctrl #(.CHAIN_LEN(N), .PASS_W(16)) dut (
        .CLK(CLK), .RSTB(RSTB), .start(start), .capture_en(capture_en),
        .abort(abort), .pattern_in(pattern_in), .scan_so(scan_so),
        .scan_se(scan_se), .scan_si(scan_si), .busy(busy), .done(done),
        .result_out(result_out), .pass_cnt(pass_cnt)
    );

    scan_chain_ctrl #(.CHAIN_LEN(4), .PASS_W(2)) dut2 (
        .CLK(CLK), .RSTB(RSTB), .start(start2), .capture_en(1'b0),
        .abort(1'b0), .pattern_in(pattern2), .scan_so(1'b0),
        .scan_se(se2), .scan_si(si2), .busy(busy2), .done(done2),
        .result_out(result2), .pass_cnt(pass2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK or negedge RSTB) begin
        if (!RSTB)        chain <= '0;
        else if (scan_se) chain <= {chain[N-2:0], scan_si};
        else if (func_en) chain <= func_val;
    end
    assign scan_so = chain[N-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Load the chain through its functional path while the controller is idle.
    task automatic preload(input logic [N-1:0] v);
        func_val = v;
        func_en  = 1'b1;
        tick();
        func_en  = 1'b0;
        exp_chain = v;
    endtask

    // One complete pass. ign >= 0 pulses a conflicting start in that shift
    // cycle; ab asserts abort together with the accepted start.
    task automatic run_pass(input logic [N-1:0] pat, input bit cap, input int ign, input bit ab);
        logic [N-1:0] exp_res;
        exp_res    = exp_chain;
        pattern_in = pat;
        capture_en = cap;
        start      = 1'b1;
        abort      = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("result_stable", result_out, last_res);
        for (int k = 0; k < N; k++) begin
            if (k == ign) begin
                start      = 1'b1;
                pattern_in = '0;
                capture_en = !cap;
            end
            check("se_shift", scan_se, 1);
            check("si_shift", scan_si, pat[N-1-k]);
            check("busy_shift", busy, 1);
            check("done_early", done, 0);
            tick();
            start = 1'b0;
        end
        if (cap) begin
            check("se_capture", scan_se, 0);
            check("si_capture", scan_si, 0);
            check("busy_capture", busy, 1);
            check("done_capture", done, 0);
            func_en = 1'b1;
            tick();
            func_en = 1'b0;
            exp_chain = func_val;
        end else begin
            exp_chain = pat;
        end
        exp_pass = exp_pass + 16'd1;
        last_res = exp_res;
        check("done_pulse", done, 1);
        check("busy_done", busy, 1);
        check("se_done", scan_se, 0);
        check("result_out", result_out, exp_res);
        check("pass_cnt", pass_cnt, exp_pass);
        check("chain_after", chain, exp_chain);
        tick();
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("result_hold", result_out, exp_res);
    endtask

    // Pass cancelled by abort asserted during shift cycle 'at'.
    task automatic abort_pass(input logic [N-1:0] pat, input int at);
        logic [N-1:0] part;
        pattern_in = pat;
        capture_en = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < at; k++) begin
            check("ab_si_shift", scan_si, pat[N-1-k]);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_se", scan_se, 0);
        check("ab_si", scan_si, 0);
        check("ab_busy", busy, 0);
        // at+1 bits shifted: old contents move up, pattern MSBs fill the bottom.
        part = (exp_chain << (at + 1)) | (pat >> (N - 1 - at));
        exp_chain = part;
        for (int k = 0; k < 3; k++) begin
            check("ab_no_done", done, 0);
            check("ab_result", result_out, last_res);
            check("ab_pass", pass_cnt, exp_pass);
            tick();
        end
        check("ab_chain", chain, exp_chain);
    endtask

    initial begin
        RSTB       = 1'b0;
        start      = 1'b0;
        capture_en = 1'b0;
        abort      = 1'b0;
        pattern_in = '0;
        start2     = 1'b0;
        pattern2   = 4'h9;
        func_en    = 1'b0;
        func_val   = '0;
        exp_chain  = '0;
        exp_pass   = '0;
        last_res   = '0;

        #3;
        check("rst_se", scan_se, 0);
        check("rst_si", scan_si, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result_out, 0);
        check("rst_pass", pass_cnt, 0);
        RSTB = 1'b1;
        tick();

        // Load/unload with a known preload.
        preload(16'hA5C3);
        run_pass(16'h1234, 1'b0, -1, 1'b0);

        // Capture pass, then a follow-up that unloads the captured value.
        func_val = 16'hFFFF;
        run_pass(16'h0F0F, 1'b1, -1, 1'b0);
        run_pass(16'h3C3C, 1'b0, -1, 1'b0);

        // Abort in shift cycle 7.
        abort_pass(16'hBEEF, 7);

        // Ignored start during shift.
        run_pass(16'h8421, 1'b0, 3, 1'b0);

        // Abort alone in IDLE does nothing; abort with start still starts.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        run_pass(16'h55AA, 1'b0, -1, 1'b1);

        // Randomized passes.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) preload(N'($urandom));
            func_val = N'($urandom);
            if ($urandom_range(0, 4) == 0)
                abort_pass(N'($urandom), int'($urandom_range(0, N - 1)));
            else
                run_pass(N'($urandom), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                         1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in shift cycle 5.
        pattern_in = 16'hF00D;
        capture_en = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        RSTB = 1'b0;
        #1;
        check("mid_rst_se", scan_se, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result_out, 0);
        check("mid_rst_pass", pass_cnt, 0);
        @(negedge CLK);
        #2;
        RSTB = 1'b1;
        tick();
        exp_chain = '0;
        exp_pass  = '0;
        last_res  = '0;
        run_pass(16'h0001, 1'b0, -1, 1'b0);

        // Pass counter wrap on the 2-bit instance.
        for (int i = 1; i <= 5; i++) begin
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            check("w_busy", busy2, 1);
            repeat (3) tick();
            check("w_done_early", done2, 0);
            tick();
            check("w_done", done2, 1);
            check("w_pass", pass2, i % 4);
            check("w_result", result2, 0);
            check("w_si", si2, 0);
            check("w_se", se2, 0);
            tick();
            check("w_done_clear", done2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
